// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if -- request/response bus of the data-memory controller.
// The master drives requests and observes responses; the slave is the controller.
interface dmem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- single-port data memory of DEPTH 32-bit words with byte/half/word
// access, sign/zero extension and a one-cycle registered response.
// After reset the array is cleared one word per cycle (INIT) before requests
// are accepted (RUN).
// Optional feature: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; without it such accesses are force-aligned.
module dmem_ctrl #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        CLK,
    input  logic        RST,
    dmem_ctrl_if.slave  bus,
    output logic        init_busy
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Lane offset actually used: halves ignore addr[0], words ignore addr[1:0].
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] off;
        case (size)
            2'b00:   off = addr_lo;
            2'b01:   off = {addr_lo[1], 1'b0};
            default: off = 2'b00;
        endcase
        return off;
    endfunction

    // Byte-lane write mask for a store of the given size at the given offset.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across lanes and merge the enabled ones.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [3:0]  be);
        logic [31:0] rep;
        logic [31:0] merged;
        case (size)
            2'b00:   rep = {4{wdata[7:0]}};
            2'b01:   rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? rep[8*i +: 8] : old_word[8*i +: 8];
        end
        return merged;
    endfunction

    // Select the addressed lane(s) of a word and extend to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off,
                                                 input logic        uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'h0000, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
            2'b10:   res = sh;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [31:0]     mem_q [DEPTH];

    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_fault_q, rsp_fault_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;

    logic            accept_s;
    logic [AW-1:0]   idx_s;
    logic            oor_s;
    logic            misalign_s;
    logic            fault_s;
    logic [1:0]      off_s;
    logic [31:0]     rd_word_s;
    logic [31:0]     wr_word_s;
    logic            mem_we_s;

    assign accept_s  = bus.req_valid && (state_q == ST_RUN) && !RST;
    assign idx_s     = bus.req_addr[AW+1:2];
    assign oor_s     = |bus.req_addr[31:AW+2];
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign_s = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif
    assign fault_s   = oor_s || (bus.req_size == 2'b11) || misalign_s;
    assign off_s     = lane_offset(bus.req_size, bus.req_addr[1:0]);
    assign rd_word_s = mem_q[idx_s];
    assign wr_word_s = store_merge(rd_word_s, bus.req_wdata, bus.req_size,
                                   byte_enables(bus.req_size, off_s));

    assign bus.req_ready = (state_q == ST_RUN);
    assign init_busy     = (state_q == ST_INIT);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // State and clear-counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= {AW{1'b0}};
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: walk the clear counter through every word, then run.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d   = ST_RUN;
                clr_cnt_d = {AW{1'b0}};
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = {AW{1'b0}};
            end
        endcase
    end

    // Response and write-enable decode for an accepted request.
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        mem_we_s    = 1'b0;
        if (accept_s) begin
            rsp_valid_d = 1'b1;
            if (fault_s) begin
                rsp_fault_d = 1'b1;
            end else if (!bus.req_wr) begin
                rsp_rdata_d = load_extract(rd_word_s, bus.req_size, off_s, bus.req_unsigned);
            end else begin
                mem_we_s = 1'b1;
            end
        end else begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response registers; reset drops any pending response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Memory array: background clear during INIT, lane-masked stores in RUN.
    always_ff @(posedge CLK) begin
        if (!RST && (state_q == ST_INIT)) begin
            mem_q[clr_cnt_q] <= 32'h0000_0000;
        end else if (mem_we_s) begin
            mem_q[idx_s] <= wr_word_s;
        end
    end

endmodule
